dmem_bus_bridge: RTL and testbench
==================================

Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the memory stage's RAM request outputs and converts its single-cycle RAM read/write requests into a valid/ready request/response bus transaction toward the data memory.
- Holds the pipeline with a stall output until the transaction completes.
- Returns the 64-bit read word for the memory stage's load alignment and sign extension.

Parameters:
- ADDR_W, 64, request address width.
- DATA_W, 64, data width; byte strobe width is DATA_W/8.
- TIMEOUT, 255, maximum cycles spent in WAIT_RESP before an error completion; the counter is 8 bits wide.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- ram_rd_en  in  1  read request from the memory stage.
- ram_wr_en  in  1  write request from the memory stage.
- ram_rd_addr  in  ADDR_W  read byte address.
- ram_wr_addr  in  ADDR_W  write byte address.
- ram_wdata  in  DATA_W  lane-shifted write data.
- ram_wmask  in  DATA_W  bit-level write mask.
- flush  in  1  drops a not-yet-issued request.
- stall  out  1  pipeline hold.
- ram_rdata  out  DATA_W  read word returned to the memory stage.
- mem_err  out  1  one-cycle error pulse, coincident with completion.
- req_valid  out  1  bus request valid.
- req_ready  in  1  bus request accepted.
- req_write  out  1  1 = write, 0 = read.
- req_addr  out  ADDR_W  8-byte-aligned address; low 3 bits are zero.
- req_wdata  out  DATA_W  write data.
- req_wstrb  out  DATA_W/8  byte strobes.
- resp_valid  in  1  response valid.
- resp_rdata  in  DATA_W  read data.
- resp_err  in  1  bus error.

Behaviour:
- Reset (rst=0, async), all outputs and registers clear:
  - state=IDLE.
  - stall, req_valid, req_write, mem_err = 0.
  - req_addr, req_wdata, req_wstrb, ram_rdata = 0.
  - Timeout counter = 0.
- A reset asserted mid-transaction abandons it immediately; any later resp_valid is ignored, since IDLE discards responses.
- Strobe derivation: wstrb[i] = OR of ram_wmask[8i+7:8i].
- Priority when ram_wr_en and ram_rd_en are both 1: the write is performed, and mem_err pulses at completion.
- Stall timing:
  - stall is combinational: 1 in IDLE when a request is present and flush=0.
  - stall is 1 in REQ and WAIT_RESP.
  - stall is 0 in DONE.
- IDLE:
  - Request present and flush=0: latch write/address/data/strobe, go to REQ; req_valid rises the next cycle.
  - Write with all-zero strobe: skip the bus and go to DONE with no error.
  - flush=1: no transaction and stall=0.
- REQ:
  - req_valid=1; all req_* outputs are held stable until req_ready.
  - On req_valid & req_ready, go to WAIT_RESP and clear the counter.
  - flush is ignored once in REQ or later; an issued request always completes.
- WAIT_RESP:
  - On resp_valid, register ram_rdata <= resp_rdata (reads only; writes leave ram_rdata unchanged) and mem_err <= resp_err.
  - Then go to DONE.
  - Each cycle without a response increments the counter. When it reaches TIMEOUT, go to DONE with mem_err=1 and ram_rdata unchanged.
  - A response arriving in the same cycle the counter hits TIMEOUT counts as the response (no error unless resp_err).
- DONE:
  - Lasts exactly one cycle with stall=0, so the pipeline advances on this edge.
  - ram_rdata and mem_err are valid in this cycle; mem_err clears afterwards, while ram_rdata holds until the next read completes.
  - Returns to IDLE; a new request is not sampled in DONE.
- Minimum latency with req_ready=1 and a next-cycle response: request seen in cycle 0, REQ in 1, WAIT_RESP in 2, DONE in 3. This gives 3 stall cycles.
- req_valid is never deasserted before req_ready.
- Only one transaction is outstanding at a time.

Decomposition:
- Shared package/defines:
  - State encoding IDLE=2'd0, REQ=2'd1, WAIT_RESP=2'd2, DONE=2'd3.
  - Reuse the existing ZERO_64, ADDR_BUS and DATA_BUS defines.
- One natural sub-module, mask_to_strb: combinational reduction of the 64-bit bit mask to the 8-bit strobe.
- FSM, request latch and timeout counter stay in dmem_bus_bridge.

Test Plan:
- Read at addr 0x80000013 with req_ready=1 and resp 0x1122334455667788 one cycle after acceptance:
  - req_addr=0x80000010, req_write=0.
  - stall high for 3 cycles.
  - ram_rdata=0x1122334455667788 in DONE; mem_err=0.
- Write SB at 0x80000005 with mask 0x0000FF0000000000:
  - req_wstrb=8'b00100000, req_wdata passes through unchanged.
  - req_valid is held across 4 cycles of req_ready=0; fields stay stable.
  - Completes on resp_valid.
- Response withheld with TIMEOUT=4: DONE reached 4 cycles after acceptance, mem_err=1 for one cycle, ram_rdata unchanged.
- flush=1 in the same cycle as ram_rd_en=1: no req_valid and stall=0. flush raised during WAIT_RESP: the transaction still completes normally.
- rd_en and wr_en both 1: a write is issued and mem_err pulses in DONE. Write with mask=0: no bus activity and a one-cycle stall.
- rst driven low during WAIT_RESP: outputs clear asynchronously; after release, a late resp_valid=1 causes no state change or rdata update.

Source files
------------

// File: rtl/dmem_bus_bridge_pkg.sv
// rtl/dmem_bus_bridge_pkg.sv - shared widths, constants and FSM encoding for the data-memory bridge
// Purpose: common definitions imported by dmem_bus_bridge and mask_to_strb.
// Contents: ADDR_BUS/DATA_BUS default widths, ZERO_64 constant, state_e encoding.
package dmem_bus_bridge_pkg;

  localparam int          ADDR_BUS = 64;
  localparam int          DATA_BUS = 64;
  localparam logic [63:0] ZERO_64  = 64'd0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_bus_bridge_mask_to_strb.sv
// rtl/dmem_bus_bridge_mask_to_strb.sv - reduces a bit-level write mask to byte strobes
// Purpose: strb_o[i] is set when any bit of byte lane i is enabled in mask_i.
// Ports:
//   mask_i  in  DATA_W    bit-level write mask
//   strb_o  out DATA_W/8  byte strobes
module mask_to_strb #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0]   mask_i,
  output logic [DATA_W/8-1:0] strb_o
);

  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_lane
    assign strb_o[i] = |mask_i[8*i +: 8];
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// rtl/dmem_bus_bridge.sv - converts single-cycle RAM requests into a valid/ready data-memory transaction
// Purpose: latches one memory-stage request, issues it on the request bus, waits for the
//          response (or a timeout), stalls the pipeline meanwhile and returns the read word.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   ram_rd_en/ram_wr_en            request strobes from the memory stage
//   ram_rd_addr/ram_wr_addr        byte addresses
//   ram_wdata/ram_wmask            lane-shifted write data and bit mask
//   flush                          drops a request that has not been issued
//   stall, ram_rdata, mem_err      pipeline hold, read word, one-cycle error pulse
//   req_*                          request channel toward data memory
//   resp_valid/resp_rdata/resp_err response channel from data memory
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int ADDR_W  = ADDR_BUS,
  parameter int DATA_W  = DATA_BUS,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ram_rd_en,
  input  logic                ram_wr_en,
  input  logic [ADDR_W-1:0]   ram_rd_addr,
  input  logic [ADDR_W-1:0]   ram_wr_addr,
  input  logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_wmask,
  input  logic                flush,
  output logic                stall,
  output logic [DATA_W-1:0]   ram_rdata,
  output logic                mem_err,
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_write,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [DATA_W-1:0]   req_wdata,
  output logic [DATA_W/8-1:0] req_wstrb,
  input  logic                resp_valid,
  input  logic [DATA_W-1:0]   resp_rdata,
  input  logic                resp_err
);

  localparam int                STRB_W     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-3){1'b1}}, 3'b000};
  // Last counter value before the timeout fires: the cycle in which the
  // increment would reach TIMEOUT is the final waiting cycle.
  localparam logic [7:0]        TMO_LAST   = 8'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                write_q;
  logic                conflict_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic [7:0]          cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q, err_d;

  logic [STRB_W-1:0]   new_strb;
  logic                req_present;
  logic                take;
  logic                skip;
  logic                tmo;

  mask_to_strb #(.DATA_W(DATA_W)) u_mask_to_strb (
    .mask_i (ram_wmask),
    .strb_o (new_strb)
  );

  assign req_present = ram_rd_en | ram_wr_en;
  assign take        = (state_q == IDLE) && req_present && !flush;
  // A write that touches no byte has nothing to do on the bus.
  assign skip        = take && ram_wr_en && (new_strb == '0);
  // A response in the final waiting cycle wins over the timeout.
  assign tmo         = (state_q == WAIT_RESP) && !resp_valid && (cnt_q == TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic (state and error pulse)
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = skip ? DONE : REQ;
          if (skip) err_d = ram_rd_en & ram_wr_en;
        end
      end
      REQ: begin
        if (req_ready) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (resp_valid) begin
          state_d = DONE;
          err_d   = resp_err | conflict_q;
        end else if (tmo) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    stall     = 1'b0;
    req_valid = 1'b0;
    case (state_q)
      IDLE:      stall = req_present && !flush;
      REQ:       begin stall = 1'b1; req_valid = 1'b1; end
      WAIT_RESP: stall = 1'b1;
      default:   stall = 1'b0;
    endcase
  end

  // Request latch, timeout counter and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q    <= 1'b0;
      conflict_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      cnt_q      <= 8'd0;
      rdata_q    <= ZERO_64[DATA_W-1:0];
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      if (take) begin
        write_q    <= ram_wr_en;
        conflict_q <= ram_rd_en & ram_wr_en;
        addr_q     <= (ram_wr_en ? ram_wr_addr : ram_rd_addr) & ALIGN_MASK;
        wdata_q    <= ram_wr_en ? ram_wdata : '0;
        strb_q     <= ram_wr_en ? new_strb : '0;
      end
      if (state_q == REQ && req_ready)
        cnt_q <= 8'd0;
      else if (state_q == WAIT_RESP && !resp_valid)
        cnt_q <= cnt_q + 8'd1;
      if (state_q == WAIT_RESP && resp_valid && !write_q)
        rdata_q <= resp_rdata;
    end
  end

  assign req_write = write_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;
  assign req_wstrb = strb_q;
  assign ram_rdata = rdata_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb/tb_dmem_bus_bridge.sv - self-checking bench for dmem_bus_bridge
module tb_dmem_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_rd_en, ram_wr_en;
  logic [63:0] ram_rd_addr, ram_wr_addr, ram_wdata, ram_wmask;
  logic        flush;
  logic        stall;
  logic [63:0] ram_rdata;
  logic        mem_err;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  dmem_bus_bridge #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
    .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .flush(flush),
    .stall(stall), .ram_rdata(ram_rdata), .mem_err(mem_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] rdata;
    logic        err;
    int          stalls;
    bit          bus;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] last_rdata = 64'd0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction. ready_wait: REQ cycles with req_ready=0.
  // resp_delay: WAIT_RESP cycles without a response before it is given.
  task automatic run_txn(input string name, input logic rd, input logic wr,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] wmask, input int ready_wait,
                         input bit give_resp, input int resp_delay,
                         input logic [63:0] rdata, input logic rerr,
                         input bit flush_in_wait);
    exp_t       e, got;
    logic [7:0] s;
    int         stalls, rw, wc, vcyc;
    bit         acc, done;
    s = 8'd0;
    for (int i = 0; i < 8; i++) s[i] = |wmask[8*i +: 8];
    e.write  = wr;
    e.addr   = {addr[63:3], 3'b000};
    e.wdata  = wr ? wdata : 64'd0;
    e.strb   = wr ? s : 8'd0;
    e.bus    = !(wr && s == 8'd0);
    e.err    = (rd && wr) ? 1'b1 : (!e.bus ? 1'b0 : (give_resp ? rerr : 1'b1));
    e.rdata  = (!wr && e.bus && give_resp) ? rdata : last_rdata;
    e.stalls = !e.bus ? 1 : 2 + ready_wait + (give_resp ? resp_delay + 1 : 4);
    sb.push_back(e);

    @(negedge clk);
    ram_rd_en = rd; ram_wr_en = wr; ram_rd_addr = addr; ram_wr_addr = addr;
    ram_wdata = wdata; ram_wmask = wmask;
    stalls = 0; rw = 0; wc = 0; vcyc = 0; acc = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      req_ready = 0; resp_valid = 0; resp_rdata = 64'd0; resp_err = 0;
      if (!stall) begin
        done = 1;
        got = sb.pop_front();
        check64({name, " rdata"}, ram_rdata, got.rdata);
        check64({name, " mem_err"}, {63'd0, mem_err}, {63'd0, got.err});
        check64({name, " stall_cycles"}, 64'(stalls), 64'(got.stalls));
        check64({name, " bus_used"}, {63'd0, vcyc > 0}, {63'd0, got.bus});
        ram_rd_en = 0; ram_wr_en = 0; flush = 0;
        last_rdata = got.rdata;
      end else begin
        stalls++;
        if (req_valid) begin
          if (vcyc == 0 || rw == ready_wait) begin
            check64({name, " req_addr"}, req_addr, e.addr);
            check64({name, " req_write"}, {63'd0, req_write}, {63'd0, e.write});
            check64({name, " req_wdata"}, req_wdata, e.wdata);
            check64({name, " req_wstrb"}, {56'd0, req_wstrb}, {56'd0, e.strb});
          end
          vcyc++;
          if (rw < ready_wait) rw++;
          else begin req_ready = 1; acc = 1; end
        end else if (acc) begin
          if (flush_in_wait) flush = 1;
          if (give_resp && wc == resp_delay) begin
            resp_valid = 1; resp_rdata = rdata; resp_err = rerr;
          end
          wc++;
        end
      end
      @(negedge clk);
    end
    n_checks++;
    assert (done) else begin
      n_fail++;
      $error("FAIL %s completion observed=not_done expected=done", name);
    end
    #1;
    check64({name, " mem_err_after"}, {63'd0, mem_err}, 64'd0);
    check64({name, " rdata_hold"}, ram_rdata, last_rdata);
    check64({name, " stall_after"}, {63'd0, stall}, 64'd0);
  endtask

  initial begin
    rst = 0; ram_rd_en = 0; ram_wr_en = 0; ram_rd_addr = 0; ram_wr_addr = 0;
    ram_wdata = 0; ram_wmask = 0; flush = 0; req_ready = 0; resp_valid = 0;
    resp_rdata = 0; resp_err = 0;
    repeat (3) @(negedge clk);
    #1;
    check64("rst stall", {63'd0, stall}, 64'd0);
    check64("rst req_valid", {63'd0, req_valid}, 64'd0);
    check64("rst req_write", {63'd0, req_write}, 64'd0);
    check64("rst mem_err", {63'd0, mem_err}, 64'd0);
    check64("rst req_addr", req_addr, 64'd0);
    check64("rst req_wdata", req_wdata, 64'd0);
    check64("rst req_wstrb", {56'd0, req_wstrb}, 64'd0);
    check64("rst ram_rdata", ram_rdata, 64'd0);
    rst = 1;

    run_txn("read", 1, 0, 64'h8000_0013, 64'd0, 64'd0, 0, 1, 0,
            64'h1122_3344_5566_7788, 0, 0);
    run_txn("write_sb", 0, 1, 64'h8000_0005, 64'h0000_AB00_0000_0000,
            64'h0000_FF00_0000_0000, 4, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    run_txn("timeout", 1, 0, 64'h8000_0020, 64'd0, 64'd0, 0, 0, 0, 64'd0, 0, 0);
    run_txn("resp_at_limit", 1, 0, 64'h8000_0028, 64'd0, 64'd0, 1, 1, 3,
            64'hDEAD_BEEF_CAFE_F00D, 0, 0);
    run_txn("resp_err", 1, 0, 64'h8000_0030, 64'd0, 64'd0, 0, 1, 1,
            64'h0123_4567_89AB_CDEF, 1, 0);
    run_txn("flush_in_wait", 1, 0, 64'h8000_0047, 64'd0, 64'd0, 0, 1, 2,
            64'hA5A5_5A5A_0F0F_F0F0, 0, 1);
    run_txn("rd_wr_both", 1, 1, 64'h8000_0050, 64'h0000_0000_0000_0077,
            64'h0000_0000_0000_00FF, 0, 1, 0, 64'd0, 0, 0);
    run_txn("zero_mask", 0, 1, 64'h8000_0058, 64'h1234, 64'd0, 0, 1, 0, 64'd0, 0, 0);

    // flush in the same cycle as the read: nothing issued, no stall
    @(negedge clk);
    ram_rd_en = 1; ram_rd_addr = 64'h8000_0060; flush = 1;
    #1;
    check64("flush stall", {63'd0, stall}, 64'd0);
    check64("flush req_valid", {63'd0, req_valid}, 64'd0);
    @(negedge clk);
    #1;
    check64("flush req_valid_next", {63'd0, req_valid}, 64'd0);
    ram_rd_en = 0; flush = 0;

    // reset during WAIT_RESP, then a stale response
    @(negedge clk);
    ram_rd_en = 1; ram_rd_addr = 64'h8000_0100;
    @(negedge clk);
    #1;
    check64("rstmid req_valid", {63'd0, req_valid}, 64'd1);
    req_ready = 1;
    @(negedge clk);
    #1;
    req_ready = 0;
    check64("rstmid waiting", {63'd0, stall}, 64'd1);
    rst = 0; ram_rd_en = 0;
    #1;
    check64("rstmid stall", {63'd0, stall}, 64'd0);
    check64("rstmid req_addr", req_addr, 64'd0);
    check64("rstmid ram_rdata", ram_rdata, 64'd0);
    @(negedge clk);
    rst = 1; resp_valid = 1; resp_rdata = 64'h5555_5555_5555_5555;
    @(negedge clk);
    resp_valid = 0;
    #1;
    check64("late_resp ram_rdata", ram_rdata, 64'd0);
    check64("late_resp stall", {63'd0, stall}, 64'd0);
    check64("late_resp mem_err", {63'd0, mem_err}, 64'd0);
    check64("late_resp req_valid", {63'd0, req_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
